// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO pointer/flag controller.
// Both the controller and its interface take their default widths from here.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_e;

  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AW       = 4;
  localparam int DEF_CW       = DEF_AW + 1;
  localparam int DEF_AF_LEVEL = 14;
  localparam int DEF_AE_LEVEL = 2;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer-side handshake, RAM strobes/addresses and status flags of fifo_ctrl.
// master = user logic driving requests, slave = the controller.
interface fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int AW = DEF_AW
);
  logic          flush;
  logic          wr_req;
  logic          rd_req;
  logic          clr_err;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  modport master (
    output flush, wr_req, rd_req, clr_err,
    input  wr_en, rd_en, wr_addr, rd_addr, count,
    input  full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, wr_req, rd_req, clr_err,
    output wr_en, rd_en, wr_addr, rd_addr, count,
    output full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_ptr_counter.sv
// AW-bit address counter that wraps DEPTH-1 -> 0 on its own bit width.
// Used for both the write and the read pointer of fifo_ctrl.
module ptr_counter
  import fifo_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [AW-1:0] q
);
  localparam logic [AW-1:0] ONE_C = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] q_r;

  // pointer register: clear has priority over advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {AW{1'b0}};
    end else if (clear) begin
      q_r <= {AW{1'b0}};
    end else if (en) begin
      q_r <= q_r + ONE_C;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer and flag controller: grants RAM read/write strobes against occupancy,
// tracks count/state, and keeps sticky overflow/underflow flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic        clk,
  input  logic        rst,
  fifo_ctrl_if.slave  bus
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  state_e        state_r, state_s;
  logic [AW:0]   count_r, count_s;
  logic          ovf_r, ovf_s;
  logic          unf_r, unf_s;
  logic          full_s, empty_s;
  logic          wr_en_s, rd_en_s;
  logic [AW-1:0] wr_addr_s, rd_addr_s;

  // status decode from registered state, plus same-cycle grants
  always_comb begin
    full_s  = (state_r == ST_FULL);
    empty_s = (state_r == ST_EMPTY);
    wr_en_s = bus.wr_req & ~full_s  & ~bus.flush & ~rst;
    rd_en_s = bus.rd_req & ~empty_s & ~bus.flush & ~rst;
  end

  // next occupancy and state; a simultaneous write+read leaves both unchanged
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    if (bus.flush) begin
      state_s = ST_EMPTY;
      count_s = {(AW+1){1'b0}};
    end else if (wr_en_s && !rd_en_s) begin
      count_s = count_r + ONE_C;
      case (state_r)
        ST_EMPTY:  state_s = ST_ACTIVE;
        ST_ACTIVE: begin
          if (count_r == DEPTH_C - ONE_C) begin
            state_s = ST_FULL;
          end else begin
            state_s = ST_ACTIVE;
          end
        end
        ST_FULL:   state_s = ST_FULL;
        default:   state_s = ST_EMPTY;
      endcase
    end else if (rd_en_s && !wr_en_s) begin
      count_s = count_r - ONE_C;
      case (state_r)
        ST_FULL:   state_s = ST_ACTIVE;
        ST_ACTIVE: begin
          if (count_r == ONE_C) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ACTIVE;
          end
        end
        ST_EMPTY:  state_s = ST_EMPTY;
        default:   state_s = ST_EMPTY;
      endcase
    end else begin
      state_s = state_r;
      count_s = count_r;
    end
  end

  // sticky errors: a new set event beats a same-cycle clear
  always_comb begin
    ovf_s = (bus.wr_req & full_s)  | (ovf_r & ~bus.clr_err);
    unf_s = (bus.rd_req & empty_s) | (unf_r & ~bus.clr_err);
  end

  // state, occupancy and error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      count_r <= {(AW+1){1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      ovf_r   <= ovf_s;
      unf_r   <= unf_s;
    end
  end

  ptr_counter #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.flush),
    .en    (wr_en_s),
    .q     (wr_addr_s)
  );

  ptr_counter #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.flush),
    .en    (rd_en_s),
    .q     (rd_addr_s)
  );

  assign bus.wr_en        = wr_en_s;
  assign bus.rd_en        = rd_en_s;
  assign bus.wr_addr      = wr_addr_s;
  assign bus.rd_addr      = rd_addr_s;
  assign bus.count        = count_r;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_r >= AF_C);
  assign bus.almost_empty = (count_r <= AE_C);
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;
endmodule
